uart_tx: RTL

Serial transmitter for the terminal path. It accepts bytes from the terminal text-buffer logic via a one-cycle valid strobe and queues them in a small FIFO. Each byte is serialized onto the UART line as an 8N1 frame (optionally 8E1), and a one-cycle done strobe is returned per completed frame. It sits between the text-buffer command engine and the board TX pin, and is the counterpart of the UART receiver that feeds the same engine.

---
 rtl/uart_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Byte-FIFO fed UART transmitter. Frames are 8N1 by default, or
//            8E1 when the UART_TX_PARITY_EN macro is defined. One-cycle done
//            strobe per completed frame, overrun strobe on dropped writes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_byte,
   input  logic       i_byte_v,
   output logic       o_byte_done,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_full,
   output logic       o_overrun
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [BW-1:0] C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_DEPTH     = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      , ST_PARITY = 3'd4
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
   logic            par_q, par_d;
`endif

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;

   logic            tx_q, done_q, busy_q, overrun_q;

   logic            w_full, w_wr, w_pop, w_baud_last, w_nonempty;

   // Full is judged on the registered count, so a same-cycle pop never frees a slot
   assign w_full      = (count_q == C_DEPTH);
   assign w_wr        = i_byte_v && !w_full;
   assign w_nonempty  = (count_q != '0);
   assign w_baud_last = (baud_q == C_BAUD_LAST);

   // Next-state, counter and shift-register logic; pops only on entry to START
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + BW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      w_pop   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            if (w_nonempty) begin
               w_pop   = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (w_baud_last) begin
               state_d = ST_DATA;
               baud_d  = '0;
               bit_d   = 3'd0;
            end
         end
         ST_DATA: begin
            if (w_baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_baud_last) begin
               state_d = ST_STOP;
               baud_d  = '0;
            end
         end
`endif
         ST_STOP: begin
            if (w_baud_last) begin
               baud_d = '0;
               if (w_nonempty) begin
                  w_pop   = 1'b1;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
         end
      endcase
      if (w_pop) begin
         shift_d = mem[rd_ptr_q];
      end
   end

`ifdef UART_TX_PARITY_EN
   // Even parity of the byte being loaded, captured before it is shifted out
   always_comb begin
      par_d = par_q;
      if (w_pop) begin
         par_d = ^mem[rd_ptr_q];
      end
   end
`endif

   // FSM state, baud counter, bit index and shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (w_wr) begin
         mem[wr_ptr_q] <= i_byte;
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_wr) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         unique case ({w_wr, w_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Registered line and status outputs; all lag the FSM state by one cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_START:  tx_q <= 1'b0;
            ST_DATA:   tx_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_q <= par_q;
`endif
            default:   tx_q <= 1'b1;
         endcase
         done_q    <= (state_q == ST_STOP) && w_baud_last;
         busy_q    <= (state_q != ST_IDLE) || w_nonempty;
         overrun_q <= i_byte_v && w_full;
      end
   end

   assign o_tx        = tx_q;
   assign o_byte_done = done_q;
   assign o_busy      = busy_q;
   assign o_full      = w_full;
   assign o_overrun   = overrun_q;

endmodule
`default_nettype wire
